// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding and timing defaults for the button debouncer
package fsm_pkg;

  // bit0 marks the level side the state belongs to or is heading towards
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    WAIT_LO = 2'b10,
    IDLE_HI = 2'b11
  } state_t;

  // 20 ms at 50 MHz
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous single-bit inputs
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic sync1;

  // no logic between the two stages so the first flop has a full cycle to settle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - push-button synchroniser, polarity fix and stability-counter debounce FSM
// Optional abort counter output enabled by DEBOUNCER_BOUNCE_CNT_EN.
module button_debouncer
  import fsm_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_WIDTH      = 20,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       level,
  output logic       busy
`ifdef DEBOUNCER_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic                 p;
  logic                 s;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 level_nxt;
  logic                 busy_nxt;

  assign p = btn_in ^ BTN_ACTIVE_LOW;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (p),
    .q     (s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    case (state)
      IDLE_LO: begin
        if (s) begin
          state_nxt = WAIT_HI;
          cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = IDLE_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HI;
          level_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_nxt = WAIT_LO;
          cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt = IDLE_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LO;
          level_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LO;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
  end

`ifdef DEBOUNCER_BOUNCE_CNT_EN
  logic abort;

  // an opposite sample while qualifying sends the FSM back to the idle state it came from
  assign abort = ((state == WAIT_HI) && !s) || ((state == WAIT_LO) && s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bounce_cnt <= 8'd0;
    end else if (abort && (bounce_cnt != 8'hFF)) begin
      bounce_cnt <= bounce_cnt + 8'd1;
    end
  end
`endif

endmodule
